// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: owns the PC, fetches words over a
// req/valid ROM handshake and issues one execute strobe per instruction.
module fetch_sequencer #(
   parameter int                   BUS_WIDTH = 16,
   parameter logic [BUS_WIDTH-1:0] PC_RESET  = '0,
   parameter int                   TIMEOUT   = 255
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_run,
   input  logic                 i_step,
   output logic                 o_rom_req,
   output logic [BUS_WIDTH-1:0] o_rom_addr,
   input  logic                 i_rom_valid,
   input  logic [BUS_WIDTH-1:0] i_rom_data,
   output logic [BUS_WIDTH-1:0] o_instr,
   output logic                 o_exec,
   input  logic                 i_j,
   input  logic [BUS_WIDTH-1:0] i_A,
   output logic [BUS_WIDTH-1:0] o_pc,
   output logic                 o_busy,
   output logic                 o_halted,
   output logic                 o_err
);
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

   // Wait count that ends the last permitted FETCH cycle without valid.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t               state_reg, state_next;
   logic [BUS_WIDTH-1:0] pc_reg, pc_next;
   logic [BUS_WIDTH-1:0] instr_reg, instr_next;
   logic [15:0]          wait_reg, wait_next;
   logic                 step_reg, step_next;
   logic                 err_reg, err_next;
   logic                 rom_req_reg, exec_reg, busy_reg, halted_reg;

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      instr_next = instr_reg;
      wait_next  = wait_reg;
      step_next  = step_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if (i_run) begin
               state_next = FETCH;
               step_next  = 1'b0;
            end else if (i_step) begin
               state_next = FETCH;
               step_next  = 1'b1;
            end
         end
         FETCH: begin
            if (i_rom_valid) begin
               instr_next = i_rom_data;
               wait_next  = '0;
               state_next = EXEC;
            end else if (wait_reg == WAIT_LAST) begin
               err_next   = 1'b1;
               state_next = HALT;
            end else begin
               wait_next = wait_reg + 16'd1;
            end
         end
         EXEC: begin
            step_next = 1'b0;
            // A taken jump onto itself can never make progress: stop here.
            if (i_j && (i_A == pc_reg)) begin
               state_next = HALT;
            end else begin
               pc_next    = i_j ? i_A : pc_reg + 1'b1;
               state_next = (i_run && !step_reg) ? FETCH : IDLE;
            end
         end
         HALT: begin
            state_next = HALT;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg   <= IDLE;
         pc_reg      <= PC_RESET;
         instr_reg   <= '0;
         wait_reg    <= '0;
         step_reg    <= 1'b0;
         err_reg     <= 1'b0;
         rom_req_reg <= 1'b0;
         exec_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         halted_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         instr_reg   <= instr_next;
         wait_reg    <= wait_next;
         step_reg    <= step_next;
         err_reg     <= err_next;
         // Status outputs are registered decodes of the upcoming state.
         rom_req_reg <= (state_next == FETCH);
         exec_reg    <= (state_next == EXEC);
         busy_reg    <= (state_next == FETCH) || (state_next == EXEC);
         halted_reg  <= (state_next == HALT);
      end
   end

   assign o_rom_req  = rom_req_reg;
   assign o_rom_addr = pc_reg;
   assign o_instr    = instr_reg;
   assign o_exec     = exec_reg;
   assign o_pc       = pc_reg;
   assign o_busy     = busy_reg;
   assign o_halted   = halted_reg;
   assign o_err      = err_reg;
endmodule
